cpu_bus_dma_arbiter: RTL



---
 rtl/cpu_bus_dma_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_dma_arbiter.sv
// cpu_bus_dma_arbiter
// Shares the 6510 external bus between the CPU core and one DMA agent.
// The CPU is halted with RDY, and the arbiter waits for a read cycle to
// complete before AEC tri-states the CPU drivers. Only then is the grant
// issued. A fixed turnaround gap with AEC low and no grant separates the
// two owners on both handoff and return.
// Optional build macro ARB_STATS_EN adds a stolen-cycle counter
// (stolen_cycles output, stats_clr input).
module cpu_bus_dma_arbiter #(
   parameter int unsigned TURN_CYCLES    = 1,
   parameter int unsigned MAX_DMA_CYCLES = 0,
   parameter int unsigned WRITE_LIMIT    = 3
) (
   input  logic        clk,
   input  logic        RESETn,
   input  logic        cyc_stb,
   input  logic        cpu_rwn,
   input  logic        dma_req,
`ifdef ARB_STATS_EN
   input  logic        stats_clr,
   output logic [15:0] stolen_cycles,
`endif
   output logic        dma_grant,
   output logic        rdy_out,
   output logic        aec_out,
   output logic        timeout,
   output logic        err_stuck
);

   typedef enum logic [2:0] {
      ST_CPU      = 3'd0,
      ST_HALT     = 3'd1,
      ST_TURN_IN  = 3'd2,
      ST_DMA      = 3'd3,
      ST_TURN_OUT = 3'd4,
      ST_RELEASE  = 3'd5
   } state_t;

   localparam logic [3:0]  TURN_LAST    = 4'(TURN_CYCLES - 1);
   localparam logic [15:0] DMA_MAX      = 16'(MAX_DMA_CYCLES);
   localparam logic [1:0]  WR_LIMIT     = 2'(WRITE_LIMIT);
   localparam logic        DMA_LIMIT_EN = (MAX_DMA_CYCLES != 0);

   state_t      state_r, state_s;
   logic [1:0]  wr_cnt_r, wr_cnt_s;
   logic [15:0] dma_cnt_r, dma_cnt_s, dma_cnt_inc_s;
   logic [3:0]  turn_cnt_r, turn_cnt_s;
   logic        rearm_r, rearm_s;
   logic        timeout_s;
   logic        err_s;

   assign dma_cnt_inc_s = dma_cnt_r + 16'd1;

   // Next-state, counter and event decode for the bus ownership sequence.
   always_comb begin
      state_s    = state_r;
      wr_cnt_s   = wr_cnt_r;
      dma_cnt_s  = dma_cnt_r;
      turn_cnt_s = turn_cnt_r;
      timeout_s  = 1'b0;
      err_s      = err_stuck;
      case (state_r)
         ST_CPU: begin
            if (dma_req && rearm_r) begin
               state_s = ST_HALT;
            end else begin
               state_s = ST_CPU;
            end
         end
         ST_HALT: begin
            // An abort beats a read cycle completing in the same clk.
            if (!dma_req) begin
               state_s  = ST_CPU;
               wr_cnt_s = 2'd0;
            end else if (cyc_stb && cpu_rwn) begin
               state_s    = ST_TURN_IN;
               turn_cnt_s = 4'd0;
               dma_cnt_s  = 16'd0;
            end else if (cyc_stb) begin
               if (wr_cnt_r == WR_LIMIT) begin
                  err_s = 1'b1;
               end else begin
                  err_s = err_stuck;
               end
               if (wr_cnt_r != 2'd3) begin
                  wr_cnt_s = wr_cnt_r + 2'd1;
               end else begin
                  wr_cnt_s = wr_cnt_r;
               end
            end else begin
               state_s = ST_HALT;
            end
         end
         ST_TURN_IN: begin
            if (!dma_req) begin
               state_s    = ST_TURN_OUT;
               turn_cnt_s = 4'd0;
            end else if (turn_cnt_r == TURN_LAST) begin
               state_s = ST_DMA;
            end else begin
               turn_cnt_s = turn_cnt_r + 4'd1;
            end
         end
         ST_DMA: begin
            if (cyc_stb) begin
               dma_cnt_s = dma_cnt_inc_s;
            end else begin
               dma_cnt_s = dma_cnt_r;
            end
            // A normal release in the limit clk takes precedence: no timeout.
            if (!dma_req) begin
               state_s    = ST_TURN_OUT;
               turn_cnt_s = 4'd0;
            end else if (DMA_LIMIT_EN && cyc_stb && (dma_cnt_inc_s == DMA_MAX)) begin
               state_s    = ST_TURN_OUT;
               turn_cnt_s = 4'd0;
               timeout_s  = 1'b1;
            end else begin
               state_s = ST_DMA;
            end
         end
         ST_TURN_OUT: begin
            if (turn_cnt_r == TURN_LAST) begin
               state_s = ST_RELEASE;
            end else begin
               turn_cnt_s = turn_cnt_r + 4'd1;
            end
         end
         ST_RELEASE: begin
            state_s  = ST_CPU;
            wr_cnt_s = 2'd0;
         end
         default: begin
            state_s  = ST_CPU;
            wr_cnt_s = 2'd0;
         end
      endcase
      // A revoked grant stays blocked until the agent lets go of the request.
      if (timeout_s) begin
         rearm_s = 1'b0;
      end else if (!dma_req) begin
         rearm_s = 1'b1;
      end else begin
         rearm_s = rearm_r;
      end
   end

   // State, counters and registered outputs decoded from the next state.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state_r    <= ST_CPU;
         wr_cnt_r   <= 2'd0;
         dma_cnt_r  <= 16'd0;
         turn_cnt_r <= 4'd0;
         rearm_r    <= 1'b1;
         rdy_out    <= 1'b1;
         aec_out    <= 1'b1;
         dma_grant  <= 1'b0;
         timeout    <= 1'b0;
         err_stuck  <= 1'b0;
      end else begin
         state_r    <= state_s;
         wr_cnt_r   <= wr_cnt_s;
         dma_cnt_r  <= dma_cnt_s;
         turn_cnt_r <= turn_cnt_s;
         rearm_r    <= rearm_s;
         rdy_out    <= (state_s == ST_CPU);
         aec_out    <= (state_s == ST_CPU) || (state_s == ST_HALT) || (state_s == ST_RELEASE);
         dma_grant  <= (state_s == ST_DMA);
         timeout    <= timeout_s;
         err_stuck  <= err_s;
      end
   end

`ifdef ARB_STATS_EN
   // Saturating count of bus cycles taken by the DMA agent; clear wins.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         stolen_cycles <= 16'd0;
      end else if (stats_clr) begin
         stolen_cycles <= 16'd0;
      end else if (cyc_stb && dma_grant && (stolen_cycles != 16'hFFFF)) begin
         stolen_cycles <= stolen_cycles + 16'd1;
      end else begin
         stolen_cycles <= stolen_cycles;
      end
   end
`endif

endmodule
